// File: rtl/bp_pkg.sv
// Shared types and defaults for the branch-predictor update controller.
package bp_pkg;

  localparam int unsigned BP_UPD_DEPTH_DEFAULT = 4;
  localparam logic [31:0] BP_INSN_BYTES        = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } bp_update_t;

  // Fall-through is pc+4 with natural 32-bit wrap.
  function automatic logic [31:0] bp_next_pc(input logic [31:0] pc,
                                             input logic        taken,
                                             input logic [31:0] target);
    return taken ? target : pc + BP_INSN_BYTES;
  endfunction

endpackage

// File: rtl/bp_update_ctrl_if.sv
// EXE-stage branch-resolution handshake into the predictor update controller.
interface bp_update_ctrl_if;

  logic        exe_valid;
  logic [31:0] exe_pc;
  logic        exe_taken;
  logic [31:0] exe_target;
  logic        exe_pred_taken;
  logic [31:0] exe_pred_target;
  logic        exe_ready;

  modport master (
    output exe_valid,
    output exe_pc,
    output exe_taken,
    output exe_target,
    output exe_pred_taken,
    output exe_pred_target,
    input  exe_ready
  );

  modport slave (
    input  exe_valid,
    input  exe_pc,
    input  exe_taken,
    input  exe_target,
    input  exe_pred_taken,
    input  exe_pred_target,
    output exe_ready
  );

endinterface

// File: rtl/bp_update_fifo.sv
// DEPTH-entry FIFO of resolved branches; head is visible combinationally.
module bp_update_fifo
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH = BP_UPD_DEPTH_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  bp_update_t din,
  input  logic       pop,
  output bp_update_t dout,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  bp_update_t      mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // DEPTH is a power of two, so pointer increment wraps modulo DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  a_no_pop_empty:  assert property (@(posedge clk) disable iff (rst) !(pop && empty));
  a_no_push_full:  assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/bp_update_ctrl.sv
// Queues resolved branches for the predictor update port and issues mispredict redirects.
// Optional BP_PERF_CNT_EN adds perf_branches / perf_mispredicts counters.
module bp_update_ctrl
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH = BP_UPD_DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  bp_update_ctrl_if.slave        exe,
  input  logic                   hold,
  output logic                   redirect_valid,
  output logic [31:0]            redirect_pc,
  output logic                   bp_update_valid,
  output logic [31:0]            bp_update_pc,
  output logic                   bp_update_taken,
  output logic [31:0]            bp_update_target
`ifdef BP_PERF_CNT_EN
  ,
  output logic [31:0]            perf_branches,
  output logic [31:0]            perf_mispredicts
`endif
);

  bp_update_t  entry;
  bp_update_t  head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        accept;
  logic [31:0] actual_next;
  logic [31:0] pred_next;
  logic        mispredict;

  assign exe.exe_ready = !fifo_full;
  assign accept        = exe.exe_valid && !fifo_full;

  assign actual_next = bp_next_pc(exe.exe_pc, exe.exe_taken, exe.exe_target);
  assign pred_next   = bp_next_pc(exe.exe_pc, exe.exe_pred_taken, exe.exe_pred_target);
  assign mispredict  = accept && (actual_next != pred_next);

  assign entry.pc     = exe.exe_pc;
  assign entry.taken  = exe.exe_taken;
  assign entry.target = exe.exe_target;

  bp_update_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .din   (entry),
    .pop   (bp_update_valid),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // hold only gates the drain side; EXE keeps filling until full.
  assign bp_update_valid  = !fifo_empty && !hold;
  assign bp_update_pc     = head.pc;
  assign bp_update_taken  = head.taken;
  assign bp_update_target = head.target;

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= mispredict;
      if (mispredict) redirect_pc <= actual_next;
    end
  end

`ifdef BP_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else begin
      if (accept)     perf_branches    <= perf_branches + 32'd1;
      if (mispredict) perf_mispredicts <= perf_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: doc/bp_update_ctrl.md
BP_UPDATE_CTRL -- requirements
Module: bp_update_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of queued branch-resolution entries (power of 2, >=2).
REQ-002 SHALL have port clk  input  1  sole clock, all state on posedge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port exe_valid  input  1  EXE-stage branch resolution present this cycle.
REQ-005 SHALL have port exe_pc  input  32  PC of resolving conditional branch.
REQ-006 SHALL have port exe_taken  input  1  actual outcome.
REQ-007 SHALL have port exe_target  input  32  actual taken target (PC+imm).
REQ-008 SHALL have ports exe_pred_taken  input  1 and exe_pred_target  input  32, meaning the prediction carried down the pipe from IF.
REQ-009 SHALL have port exe_ready  output  1  entry accepted; EXE stalls when low.
REQ-010 SHALL have port hold  input  1  freeze predictor update port (e.g. IF freeze).
REQ-011 SHALL have port redirect_valid  output  1  one-cycle mispredict redirect pulse.
REQ-012 SHALL have port redirect_pc  output  32  correct next PC.
REQ-013 SHALL have ports bp_update_valid  output  1, bp_update_pc  output  32, bp_update_taken  output  1 and bp_update_target  output  32, meaning they drive the predictor update port.

Function
REQ-014 SHALL accept an entry when exe_valid && exe_ready; exe_ready = (count != DEPTH), with no same-cycle bypass when full.
REQ-015 SHALL compute actual_next = exe_taken ? exe_target : exe_pc+4 and pred_next = exe_pred_taken ? exe_pred_target : exe_pc+4, using 32-bit wrap-around arithmetic.
REQ-016 SHALL, on an accepted entry with actual_next != pred_next, assert redirect_valid on the next cycle for exactly one cycle, with redirect_pc = actual_next.
REQ-017 SHALL hold redirect_pc at its last value and keep redirect_valid low whenever no mispredicting entry was accepted the previous cycle, including all unaccepted cycles.
REQ-018 SHALL store {exe_pc, exe_taken, exe_target} in FIFO order; the queue holds only resolved (non-speculative) branches and a redirect never flushes it.
REQ-019 SHALL drive bp_update_pc/taken/target combinationally from the FIFO head, with bp_update_valid = !empty && !hold.
REQ-020 SHALL pop the head in every cycle in which bp_update_valid is high, giving at most one predictor update per cycle.
REQ-021 SHALL make an accepted entry presentable on the update port no earlier than the cycle after acceptance, and no empty-queue bypass is permitted.
REQ-022 SHALL, on a simultaneous push and pop, leave count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-023 SHALL let hold block pops only; acceptance continues until full.

Reset
REQ-024 SHALL, while rst is high, drive read/write pointers and count to 0, redirect_valid to 0, redirect_pc to 32'h0 and perf counters to 0.
REQ-025 SHALL make bp_update_valid 0 and exe_ready 1 in the cycle after reset; a reset mid-operation discards queued entries and any pending redirect.

Configuration
REQ-026 SHALL, with BP_PERF_CNT_EN defined, add outputs perf_branches[31:0] (accepted entries) and perf_mispredicts[31:0] (redirects issued), each incrementing by 1 and wrapping at 2^32.
REQ-027 SHALL, with BP_PERF_CNT_EN undefined, omit those ports and counters entirely, leaving all other behaviour identical.

Structure
REQ-028 SHALL define, in shared package bp_pkg, typedef bp_update_t {pc[31:0], taken, target[31:0]} and constant BP_UPD_DEPTH_DEFAULT=4.
REQ-029 SHALL implement storage in one sub-module, bp_update_fifo (DEPTH x bp_update_t, push/pop/full/empty).

Verification
REQ-030 SHALL cover: pc=0x100, taken=1, target=0x80, pred_taken=0 -> redirect_valid pulse next cycle with redirect_pc=0x80; bp_update shows {0x100,1,0x80} that cycle.
REQ-031 SHALL cover: pc=0x200, taken=0, pred_taken=1, pred_target=0x300 -> redirect_pc=0x204; pred_taken=1 with pred_target=exe_target=0x300 and taken=1 -> no redirect.
REQ-032 SHALL cover: hold=1, 5 back-to-back branches -> 4 accepted, exe_ready low on 5th; release hold -> 4 updates in consecutive cycles in FIFO order, then exe_ready=1.
REQ-033 SHALL cover: with count=2 and hold=0, push and pop in the same cycle -> count stays 2; run 10 entries to verify pointer wrap and order.
REQ-034 SHALL cover: rst asserted with 3 entries queued -> bp_update_valid=0 next cycle, no redirect, and perf counters 0 (BP_PERF_CNT_EN).
REQ-035 SHALL cover: pc=0xFFFFFFFC, taken=0, pred_taken=1 -> redirect_pc=0x00000000 (wrap).
